i2s_mic_receiver: RTL and testbench

Front-end stage of the audio chain: drives the I2S microphone's bit clock (`mic_sck`) and word select (`mic_ws`) from `audio_clk` and deserializes one channel's 24-bit MSB-first samples. It emits a 16-bit signed sample with a single-cycle `mic_data_valid` strobe. Its outputs connect directly to the `raw_audio_single_cycle` / `mic_data_valid` inputs of the DC-offset / anti-alias / decimation stage, at 48 kHz with the default parameters.

---
 rtl/i2s_mic_if.sv | 16 +
 rtl/i2s_mic_receiver.sv | 63 ++++++
 tb/tb_i2s_mic_receiver.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/i2s_mic_if.sv
// i2s_mic_if: microphone pins and sample output of the I2S mic receiver.
interface i2s_mic_if;
    logic        mic_sd;
    logic        mic_sck;
    logic        mic_ws;
    logic [15:0] raw_audio_single_cycle;
    logic        mic_data_valid;
    modport master (
        input  mic_sd,
        output mic_sck, mic_ws, raw_audio_single_cycle, mic_data_valid
    );
    modport slave (
        output mic_sd,
        input  mic_sck, mic_ws, raw_audio_single_cycle, mic_data_valid
    );
endinterface

// File: rtl/i2s_mic_receiver.sv
// i2s_mic_receiver: generates I2S SCK/WS and captures one channel's 24-bit word as a 16-bit sample.
module i2s_mic_receiver #(
    parameter int CLK_DIV = 16,
    parameter bit CHANNEL = 1'b0
) (
    input logic       audio_clk,
    input logic       rst_in,
    i2s_mic_if.master mic
);
    localparam int DW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
    localparam logic [DW-1:0] DIV_MAX = DW'(CLK_DIV - 1);
    logic [DW-1:0] div_q, div_d;
    logic          sck_q, sck_d;
    logic [5:0]    bit_q, bit_d;
    logic [23:0]   shift_q, shift_d;
    logic [15:0]   raw_q, raw_d;
    logic          valid_q, valid_d;
    logic          sync_q, sd_s_q;
    logic          wrap, rise, fall, sel, cap;
    logic [4:0]    b;
    logic [23:0]   word;
    always_comb begin
        wrap    = div_q == DIV_MAX;
        rise    = wrap && !sck_q;
        fall    = wrap && sck_q;
        b       = bit_q[4:0];
        sel     = bit_q[5] == CHANNEL;
        // one-bit I2S delay: slots 1..24 carry MSB..LSB
        cap     = rise && sel && b >= 5'd1 && b <= 5'd24;
        word    = {shift_q[22:0], sd_s_q};
        div_d   = wrap ? '0 : div_q + 1'b1;
        sck_d   = wrap ? !sck_q : sck_q;
        bit_d   = fall ? bit_q + 6'd1 : bit_q;
        shift_d = cap ? word : shift_q;
        valid_d = cap && b == 5'd24;
        raw_d   = valid_d ? word[23:8] : raw_q;
    end
    always_ff @(posedge audio_clk) begin
        if (rst_in) begin
            div_q   <= '0;
            sck_q   <= 1'b0;
            bit_q   <= '0;
            shift_q <= '0;
            raw_q   <= '0;
            valid_q <= 1'b0;
            sync_q  <= 1'b0;
            sd_s_q  <= 1'b0;
        end else begin
            div_q   <= div_d;
            sck_q   <= sck_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            raw_q   <= raw_d;
            valid_q <= valid_d;
            sync_q  <= mic.mic_sd;
            sd_s_q  <= sync_q;
        end
    end
    assign mic.mic_sck                = sck_q;
    assign mic.mic_ws                 = bit_q[5];
    assign mic.raw_audio_single_cycle = raw_q;
    assign mic.mic_data_valid         = valid_q;
endmodule

// File: tb/tb_i2s_mic_receiver.sv
// tb_i2s_mic_receiver: three receiver variants driven by behavioural I2S mics, checked against strobe timing/value arithmetic.
module tb_i2s_mic_receiver;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    i2s_mic_if m0 ();
    i2s_mic_if m1 ();
    i2s_mic_if m2 ();
    i2s_mic_receiver #(.CLK_DIV(16), .CHANNEL(1'b0)) u0 (.audio_clk(clk), .rst_in(rst), .mic(m0));
    i2s_mic_receiver #(.CLK_DIV(16), .CHANNEL(1'b1)) u1 (.audio_clk(clk), .rst_in(rst), .mic(m1));
    i2s_mic_receiver #(.CLK_DIV(4),  .CHANNEL(1'b0)) u2 (.audio_clk(clk), .rst_in(rst), .mic(m2));

    int total = 0;
    int bad = 0;
    int ecnt = 0;
    logic [23:0] lw [3][24];
    logic [23:0] rw [3][24];
    logic        pad [3];
    int          fo [3];
    int          sl [3];
    logic        pv [3];
    logic        pd [3];
    int          lc [3];
    int          st [3];
    int          le [3][64];
    logic [15:0] ld [3][64];
    logic [2:0]  sck_v, ws_v, val_v;
    logic [2:0]  sd_v = 3'b000;
    logic [15:0] raw_v [3];

    assign sck_v = {m2.mic_sck, m1.mic_sck, m0.mic_sck};
    assign ws_v  = {m2.mic_ws, m1.mic_ws, m0.mic_ws};
    assign val_v = {m2.mic_data_valid, m1.mic_data_valid, m0.mic_data_valid};
    assign raw_v[0] = m0.raw_audio_single_cycle;
    assign raw_v[1] = m1.raw_audio_single_cycle;
    assign raw_v[2] = m2.raw_audio_single_cycle;
    assign m0.mic_sd = sd_v[0];
    assign m1.mic_sd = sd_v[1];
    assign m2.mic_sd = sd_v[2];

    function automatic int dv(int i);
        return (i == 2) ? 4 : 16;
    endfunction

    function automatic int ch(int i);
        return (i == 1) ? 1 : 0;
    endfunction

    // Mic behaviour: slot s counts SCK falls since reset; slot 1..24 of a half carries word bit 24-s.
    function automatic logic bitval(int i, int s);
        int f, t, b;
        logic [23:0] w;
        f = (fo[i] + s / 64) % 24;
        t = s % 64;
        b = t % 32;
        if (b < 1 || b > 24) return pad[i];
        w = (t >= 32) ? rw[i][f] : lw[i][f];
        return w[24 - b];
    endfunction

    always @(posedge clk) ecnt <= rst ? 0 : ecnt + 1;

    always @(posedge clk) begin
        #1;
        for (int i = 0; i < 3; i++) begin
            if (rst) begin
                sl[i] = 0;
                pv[i] = 1'b0;
                pd[i] = 1'b0;
                sd_v[i] = pad[i];
            end else begin
                if (pd[i]) begin
                    sd_v[i] = bitval(i, sl[i]);
                    pd[i] = 1'b0;
                end
                if (pv[i] && !sck_v[i]) begin
                    sl[i]++;
                    pd[i] = 1'b1;
                end
                pv[i] = sck_v[i];
                if (val_v[i] && lc[i] < 64) begin
                    le[i][lc[i]] = ecnt;
                    ld[i][lc[i]] = raw_v[i];
                    lc[i]++;
                end
            end
        end
    end

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic run_to(int e);
        while (ecnt < e) @(negedge clk);
    endtask

    task automatic check_log(int i, int start, int endv);
        int base, per, n, got;
        logic [23:0] w;
        base = (49 + 64 * ch(i)) * dv(i);
        per  = 128 * dv(i);
        n    = 0;
        got  = lc[i] - start;
        while (base + per * n <= endv) n++;
        chk($sformatf("strobe_count u%0d", i), got, n);
        for (int k = 0; k < n && k < got; k++) begin
            w = ch(i) ? rw[i][fo[i] + k] : lw[i][fo[i] + k];
            chk($sformatf("strobe_edge u%0d k%0d", i, k), le[i][start + k], base + per * k);
            chk($sformatf("strobe_data u%0d k%0d", i, k), {16'h0, ld[i][start + k]}, {16'h0, w[23:8]});
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 3; i++) begin
            lc[i] = 0;
            st[i] = 0;
            fo[i] = 0;
            for (int k = 0; k < 24; k++) begin
                lw[i][k] = 24'($urandom);
                rw[i][k] = 24'($urandom);
            end
        end
        pad[0] = 1'b0;
        pad[1] = 1'b1;
        pad[2] = 1'b0;
        lw[0][0] = 24'h123456;
        lw[0][1] = 24'h800001;
        lw[0][2] = 24'h7FFFFF;
        lw[0][3] = 24'hFFFF00;
        for (int k = 0; k < 24; k++) begin
            rw[0][k] = 24'hFFFFFF;
            rw[1][k] = 24'hA5A5A5;
        end
        rst = 1'b1;
        repeat (5) begin
            @(negedge clk);
            for (int i = 0; i < 3; i++) begin
                chk($sformatf("rst_sck u%0d", i), {31'h0, sck_v[i]}, 0);
                chk($sformatf("rst_ws u%0d", i), {31'h0, ws_v[i]}, 0);
                chk($sformatf("rst_valid u%0d", i), {31'h0, val_v[i]}, 0);
                chk($sformatf("rst_raw u%0d", i), {16'h0, raw_v[i]}, 0);
            end
        end
        rst = 1'b0;
        run_to(15);
        chk("sck u0 e15", {31'h0, sck_v[0]}, 0);
        chk("sck u2 e15", {31'h0, sck_v[2]}, 1);
        run_to(16);
        chk("sck u0 e16", {31'h0, sck_v[0]}, 1);
        chk("sck u2 e16", {31'h0, sck_v[2]}, 0);
        run_to(31);
        chk("sck u0 e31", {31'h0, sck_v[0]}, 1);
        run_to(32);
        chk("sck u0 e32", {31'h0, sck_v[0]}, 0);
        chk("ws u0 e32", {31'h0, ws_v[0]}, 0);
        run_to(255);
        chk("ws u2 e255", {31'h0, ws_v[2]}, 0);
        run_to(256);
        chk("ws u2 e256", {31'h0, ws_v[2]}, 1);
        run_to(1023);
        chk("ws u0 e1023", {31'h0, ws_v[0]}, 0);
        run_to(1024);
        chk("ws u0 e1024", {31'h0, ws_v[0]}, 1);
        run_to(9000);
        for (int i = 0; i < 3; i++) check_log(i, 0, 9000);

        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        run_to(390);
        rst = 1'b1;
        for (int i = 0; i < 3; i++) fo[i] = 1;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) st[i] = lc[i];
        run_to(2900);
        for (int i = 0; i < 3; i++) check_log(i, st[i], 2900);

        rst = 1'b1;
        for (int i = 0; i < 3; i++) fo[i] = 0;
        @(negedge clk);
        rst = 1'b0;
        run_to(783);
        rst = 1'b1;
        @(negedge clk);
        chk("rst_on_strobe valid u0", {31'h0, val_v[0]}, 0);
        chk("rst_on_strobe raw u0", {16'h0, raw_v[0]}, 0);
        chk("rst_on_strobe sck u0", {31'h0, sck_v[0]}, 0);
        rst = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
